// File: rtl/queue_pcount.sv
// Queue occupancy counter fed by two debounced photocells.
// Front beam arrivals increment, rear beam departures decrement, saturating.
module queue_pcount #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_COUNT       = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sens_front,
  input  logic       sens_rear,
  output logic [2:0] pcount,
  output logic       full,
  output logic       empty,
  output logic       err_full,
  output logic       err_empty
);

  localparam logic [3:0] LP_DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] LP_MAX     = 3'(MAX_COUNT);

  logic [1:0] w_raw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [3:0] r_cnt [2];
  logic [1:0] r_filt;
  logic [1:0] r_prev;
  logic [1:0] w_rise;

  logic       w_arrival;
  logic       w_departure;
  logic [2:0] w_pcount_nxt;
  logic       w_err_full_nxt;
  logic       w_err_empty_nxt;

  logic [2:0] r_pcount;
  logic       r_full;
  logic       r_empty;
  logic       r_err_full;
  logic       r_err_empty;

  assign w_raw = {sens_rear, sens_front};

  // Index 0 is the front (entry) beam, index 1 the rear (exit) beam.
  for (genvar g = 0; g < 2; g++) begin : g_sens
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sync1[g] <= 1'b0;
        r_sync2[g] <= 1'b0;
        r_cnt[g]   <= 4'd0;
        r_filt[g]  <= 1'b0;
        r_prev[g]  <= 1'b0;
      end else begin
        r_sync1[g] <= w_raw[g];
        r_sync2[g] <= r_sync1[g];
        r_prev[g]  <= r_filt[g];
        if (r_sync2[g] == r_filt[g]) begin
          r_cnt[g] <= 4'd0;
        end else if (r_cnt[g] == LP_DB_LAST) begin
          r_filt[g] <= r_sync2[g];
          r_cnt[g]  <= 4'd0;
        end else begin
          r_cnt[g] <= r_cnt[g] + 4'd1;
        end
      end
    end
  end

  assign w_rise      = r_filt & ~r_prev;
  assign w_arrival   = w_rise[0];
  assign w_departure = w_rise[1];

  always_comb begin
    w_pcount_nxt    = r_pcount;
    w_err_full_nxt  = 1'b0;
    w_err_empty_nxt = 1'b0;
    unique case (1'b1)
      w_arrival & ~w_departure: begin
        if (r_pcount == LP_MAX) w_err_full_nxt = 1'b1;
        else                    w_pcount_nxt = r_pcount + 3'd1;
      end
      w_departure & ~w_arrival: begin
        if (r_pcount == 3'd0) w_err_empty_nxt = 1'b1;
        else                  w_pcount_nxt = r_pcount - 3'd1;
      end
      default: ;
    endcase
  end

  // Flags are registered alongside the count so all outputs move together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pcount    <= 3'd0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_err_full  <= 1'b0;
      r_err_empty <= 1'b0;
    end else begin
      r_pcount    <= w_pcount_nxt;
      r_full      <= (w_pcount_nxt == LP_MAX);
      r_empty     <= (w_pcount_nxt == 3'd0);
      r_err_full  <= w_err_full_nxt;
      r_err_empty <= w_err_empty_nxt;
    end
  end

  assign pcount    = r_pcount;
  assign full      = r_full;
  assign empty     = r_empty;
  assign err_full  = r_err_full;
  assign err_empty = r_err_empty;

endmodule

// File: tb/tb_queue_pcount.sv
// Bench for queue_pcount: window-rule reference model feeding a
// per-cycle scoreboard, plus directed scenario checks.
module tb_queue_pcount;

  localparam int D  = 4;
  localparam int MX = 7;

  logic       clk;
  logic       rst_n;
  logic       sens_front;
  logic       sens_rear;
  logic [2:0] pcount;
  logic       full;
  logic       empty;
  logic       err_full;
  logic       err_empty;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0] pc;
    logic       full;
    logic       empty;
    logic       ef;
    logic       ee;
  } exp_t;

  exp_t exp_q[$];

  queue_pcount #(
    .DEBOUNCE_CYCLES(D),
    .MAX_COUNT(MX)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sens_front(sens_front),
    .sens_rear(sens_rear),
    .pcount(pcount),
    .full(full),
    .empty(empty),
    .err_full(err_full),
    .err_empty(err_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // A beam's filtered level flips once the D samples taken 2..D+1 edges
  // ago all disagree with it; bit 0 of h is the sample at this edge.
  function automatic bit flips(input logic [31:0] h, input int n,
                               input bit filt);
    if (n < D + 2) return 1'b0;
    for (int k = 2; k <= D + 1; k++)
      if (h[k] == filt) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: one expected output set pushed per rising edge.
  initial begin
    int m_cnt;
    int nh;
    logic [31:0] hf;
    logic [31:0] hr;
    bit ff, fr, pa, pd;
    exp_t e;
    m_cnt = 0; nh = 0; hf = '0; hr = '0;
    ff = 0; fr = 0; pa = 0; pd = 0;
    forever begin
      @(posedge clk);
      e.pc = 3'd0; e.full = 1'b0; e.empty = 1'b1;
      e.ef = 1'b0; e.ee = 1'b0;
      if (!rst_n) begin
        m_cnt = 0; nh = 0; hf = '0; hr = '0;
        ff = 0; fr = 0; pa = 0; pd = 0;
      end else begin
        if (pa && !pd) begin
          if (m_cnt == MX) e.ef = 1'b1;
          else m_cnt++;
        end else if (pd && !pa) begin
          if (m_cnt == 0) e.ee = 1'b1;
          else m_cnt--;
        end
        hf = {hf[30:0], sens_front};
        hr = {hr[30:0], sens_rear};
        if (nh < 31) nh++;
        pa = 0; pd = 0;
        if (flips(hf, nh, ff)) begin ff = !ff; pa = ff; end
        if (flips(hr, nh, fr)) begin fr = !fr; pd = fr; end
      end
      e.pc    = 3'(m_cnt);
      e.full  = (m_cnt == MX);
      e.empty = (m_cnt == 0);
      exp_q.push_back(e);
    end
  end

  // Monitor: compare DUT outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_pcount", int'(pcount), int'(e.pc));
        chk("sb_full", int'(full), int'(e.full));
        chk("sb_empty", int'(empty), int'(e.empty));
        chk("sb_err_full", int'(err_full), int'(e.ef));
        chk("sb_err_empty", int'(err_empty), int'(e.ee));
      end
    end
  end

  task automatic pulse(input bit f, input bit r, input int hi);
    sens_front = f;
    sens_rear  = r;
    repeat (hi) @(negedge clk);
    sens_front = 1'b0;
    sens_rear  = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int hold;
    rst_n = 1'b0;
    sens_front = 1'b0;
    sens_rear  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pcount", int'(pcount), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // First arrival: latency of D+3 edges.
    sens_front = 1'b1;
    repeat (D + 2) @(negedge clk);
    chk("lat_before", int'(pcount), 0);
    chk("lat_empty_before", int'(empty), 1);
    @(negedge clk);
    chk("lat_at", int'(pcount), 1);
    chk("lat_empty_at", int'(empty), 0);
    repeat (3) @(negedge clk);
    sens_front = 1'b0;
    repeat (10) @(negedge clk);

    repeat (MX - 1) pulse(1'b1, 1'b0, 8);
    chk("fill_pcount", int'(pcount), MX);
    chk("fill_full", int'(full), 1);
    pulse(1'b1, 1'b0, 8);
    chk("over_pcount", int'(pcount), MX);
    pulse(1'b1, 1'b1, 8);
    chk("both_at_max", int'(pcount), MX);

    repeat (MX) pulse(1'b0, 1'b1, 8);
    chk("drain_pcount", int'(pcount), 0);
    pulse(1'b1, 1'b1, 8);
    chk("both_at_zero", int'(pcount), 0);
    pulse(1'b0, 1'b1, 8);
    chk("under_pcount", int'(pcount), 0);
    chk("under_empty", int'(empty), 1);
    repeat (3) pulse(1'b1, 1'b0, 8);
    pulse(1'b0, 1'b1, 8);
    chk("mix_pcount", int'(pcount), 2);
    pulse(1'b1, 1'b0, 8);
    pulse(1'b1, 1'b1, 8);
    chk("both_at_3", int'(pcount), 3);

    // Glitch train shorter than the debounce window.
    repeat (10) begin
      sens_front = 1'b1;
      repeat (2) @(negedge clk);
      sens_front = 1'b0;
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("glitch_pcount", int'(pcount), 3);

    repeat (2) pulse(1'b1, 1'b0, 8);
    chk("pre_rst_pcount", int'(pcount), 5);

    // Reset mid-debounce with the front beam still blocked.
    sens_front = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_pcount", int'(pcount), 0);
    chk("midrst_empty", int'(empty), 1);
    repeat (D + 2) @(negedge clk);
    chk("midrst_before", int'(pcount), 0);
    @(negedge clk);
    chk("midrst_after", int'(pcount), 1);
    repeat (20) @(negedge clk);
    chk("held_high_once", int'(pcount), 1);
    sens_front = 1'b0;
    repeat (10) @(negedge clk);

    // Randomized traffic, checked by the scoreboard.
    repeat (400) begin
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      hold = int'($urandom_range(1, 12));
      if ($urandom_range(0, 3) == 0) begin
        sens_front = 1'($urandom_range(0, 1));
        sens_rear  = sens_front;
      end else begin
        sens_front = 1'($urandom_range(0, 1));
        sens_rear  = 1'($urandom_range(0, 1));
      end
      repeat (hold) @(negedge clk);
    end
    sens_front = 1'b0;
    sens_rear  = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
